// File: rtl/button_events_if.sv
// button_events_if
//   Groups the pushbutton pin and the conditioned event outputs of
//   button_events into one bundle.
//   Signals:
//     btn           raw pushbutton pin (asynchronous, bouncing)
//     btn_level     debounced level, 1 = pressed
//     press         1-cycle pulse on debounced press
//     release_pulse 1-cycle pulse on debounced release ("release" is reserved)
//     short_click   1-cycle pulse on release when no long press fired
//     long_press    1-cycle pulse once per press after the long hold time
//     mode          3-bit pattern select
//   Modports:
//     master  the button_events side (consumes btn, drives the events)
//     slave   the pin / LED pattern logic side
`timescale 1ns/1ps
interface button_events_if;
    logic       btn;
    logic       btn_level;
    logic       press;
    logic       release_pulse;
    logic       short_click;
    logic       long_press;
    logic [2:0] mode;

    modport master (
        input  btn,
        output btn_level, press, release_pulse, short_click, long_press, mode
    );

    modport slave (
        output btn,
        input  btn_level, press, release_pulse, short_click, long_press, mode
    );
endinterface

// File: rtl/button_events.sv
// button_events
//   Conditions one raw pushbutton into clean single-cycle events for the
//   LED pattern logic: 2-FF synchroniser, debouncer, short/long press
//   classifier and a 3-bit MODE register.
//   Parameters:
//     DEBOUNCE_CYCLES  synced cycles the input must differ before btn_level flips (>= 2)
//     LONG_CYCLES      cycles btn_level must stay pressed before long_press (>= 2)
//     ACTIVE_LOW       1: pin reads 0 when pressed; 0: pin reads 1 when pressed
//   Ports:
//     clk    system clock
//     rst_n  asynchronous active-low reset
//     bus    button_events_if.master (btn in; btn_level, press, release_pulse,
//            short_click, long_press, mode out)
`timescale 1ns/1ps
module button_events #(
    parameter int unsigned DEBOUNCE_CYCLES = 120000,
    parameter int unsigned LONG_CYCLES     = 12000000,
    parameter bit          ACTIVE_LOW      = 1'b1
) (
    input  logic            clk,
    input  logic            rst_n,
    button_events_if.master bus
);
    localparam int unsigned   DB_W      = $clog2(DEBOUNCE_CYCLES);
    localparam int unsigned   HOLD_W    = $clog2(LONG_CYCLES);
    localparam logic [DB_W-1:0]   DB_LAST   = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(LONG_CYCLES - 1);
    // Raw pin value while released; the sync flops reset to it so leaving
    // reset never looks like a press.
    localparam logic          RAW_IDLE  = ACTIVE_LOW;

    typedef enum logic [1:0] {
        IDLE = 2'd0,  // released
        HELD = 2'd1,  // pressed, long press not yet fired
        LONG = 2'd2   // pressed, long press fired
    } state_t;

    logic              sync1, sync2;
    logic              p_sync;
    logic [DB_W-1:0]   db_cnt;
    logic              level;
    logic              differ, db_done, rise, fall;

    state_t            state, state_n;
    logic [HOLD_W-1:0] hold_cnt, hold_n;
    logic [2:0]        mode, mode_n;
    logic              press, press_n;
    logic              rel, rel_n;
    logic              short_c, short_n;
    logic              long_p, long_n;

    // Synchroniser and debouncer
    assign p_sync  = sync2 ^ ACTIVE_LOW;
    assign differ  = (p_sync != level);
    assign db_done = differ && (db_cnt == DB_LAST);
    // rise/fall mark the edge on which btn_level flips, so the FSM can
    // register its pulses alongside the new level.
    assign rise    = db_done && !level;
    assign fall    = db_done && level;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1  <= RAW_IDLE;
            sync2  <= RAW_IDLE;
            db_cnt <= '0;
            level  <= 1'b0;
        end else begin
            sync1 <= bus.btn;
            sync2 <= sync1;
            if (!differ) begin
                db_cnt <= '0;
            end else if (db_done) begin
                db_cnt <= '0;
                level  <= ~level;
            end else begin
                db_cnt <= db_cnt + 1'b1;
            end
        end
    end

    // Press classifier FSM
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            hold_cnt <= '0;
            mode     <= '0;
            press    <= 1'b0;
            rel      <= 1'b0;
            short_c  <= 1'b0;
            long_p   <= 1'b0;
        end else begin
            state    <= state_n;
            hold_cnt <= hold_n;
            mode     <= mode_n;
            press    <= press_n;
            rel      <= rel_n;
            short_c  <= short_n;
            long_p   <= long_n;
        end
    end

    always_comb begin
        state_n = state;
        hold_n  = hold_cnt;
        mode_n  = mode;
        press_n = 1'b0;
        rel_n   = 1'b0;
        short_n = 1'b0;
        long_n  = 1'b0;
        case (state)
            IDLE: begin
                if (rise) begin
                    state_n = HELD;
                    hold_n  = '0;
                    press_n = 1'b1;
                end
            end
            HELD: begin
                // A release landing on the hold terminal edge is a short click.
                if (fall) begin
                    state_n = IDLE;
                    rel_n   = 1'b1;
                    short_n = 1'b1;
                    mode_n  = mode + 3'd1;
                end else if (hold_cnt == HOLD_LAST) begin
                    state_n = LONG;
                    long_n  = 1'b1;
                    mode_n  = '0;
                end else begin
                    hold_n = hold_cnt + 1'b1;
                end
            end
            LONG: begin
                if (fall) begin
                    state_n = IDLE;
                    rel_n   = 1'b1;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    assign bus.btn_level     = level;
    assign bus.press         = press;
    assign bus.release_pulse = rel;
    assign bus.short_click   = short_c;
    assign bus.long_press    = long_p;
    assign bus.mode          = mode;
endmodule

// File: tb/tb_button_events.sv
// tb_button_events
//   Self-checking bench for button_events with DEBOUNCE_CYCLES=4,
//   LONG_CYCLES=20, ACTIVE_LOW=1 and an 83.33 ns clock. Expected events
//   are queued with the cycle they are due; a monitor on the falling edge
//   pops and compares them and flags any pulse nobody asked for.
`timescale 1ns/1ps
module tb_button_events;
    localparam int unsigned DB  = 4;
    localparam int unsigned LC  = 20;
    localparam int          LAT = DB + 2;

    localparam logic [3:0] EV_PRESS = 4'b1000;
    localparam logic [3:0] EV_REL   = 4'b0100;
    localparam logic [3:0] EV_SHORT = 4'b0010;
    localparam logic [3:0] EV_LONG  = 4'b0001;

    typedef struct {
        int         cyc;
        logic [3:0] ev;
        logic [2:0] mode;
        logic       level;
    } exp_t;

    typedef struct {
        int         hold;
        bit         is_long;
        logic [2:0] mode;
    } click_t;

    logic clk    = 1'b0;
    logic rst_n  = 1'b1;
    int   cyc    = 0;
    int   checks = 0;
    int   errors = 0;
    bit   mon_en = 1'b0;
    exp_t sb[$];

    button_events_if bus ();

    button_events #(
        .DEBOUNCE_CYCLES (DB),
        .LONG_CYCLES     (LC),
        .ACTIVE_LOW      (1'b1)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #41.665 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        logic [3:0] got;
        exp_t       e;
        if (mon_en) begin
            got = {bus.press, bus.release_pulse, bus.short_click, bus.long_press};
            if (sb.size() > 0 && sb[0].cyc <= cyc) begin
                e = sb.pop_front();
                checks++;
                if (e.cyc != cyc || got !== e.ev || bus.mode !== e.mode || bus.btn_level !== e.level) begin
                    errors++;
                    $display("FAIL event at cycle %0d: got pulses=%b mode=%0d level=%b, required pulses=%b mode=%0d level=%b due cycle %0d",
                             cyc, got, bus.mode, bus.btn_level, e.ev, e.mode, e.level, e.cyc);
                end
            end else begin
                checks++;
                if (got !== 4'b0000) begin
                    errors++;
                    $display("FAIL stray pulse at cycle %0d: got pulses=%b, required 0000", cyc, got);
                end
            end
        end
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] req);
        checks++;
        if (got !== req) begin
            errors++;
            $display("FAIL %s: got %0h, required %0h", name, got, req);
        end
    endtask

    task automatic push(input int c, input logic [3:0] ev, input logic [2:0] m, input logic lv);
        exp_t e;
        e.cyc   = c;
        e.ev    = ev;
        e.mode  = m;
        e.level = lv;
        sb.push_back(e);
    endtask

    task automatic wait_until(input int c);
        while (cyc < c) @(negedge clk);
    endtask

    function automatic logic [7:0] all_outputs();
        return {bus.btn_level, bus.press, bus.release_pulse, bus.short_click,
                bus.long_press, bus.mode};
    endfunction

    task automatic run_click(input int hold, input bit is_long,
                             input logic [2:0] mode_before, input logic [2:0] mode_after);
        int p;
        int r;
        @(negedge clk);
        bus.btn = 1'b0;
        p = cyc + LAT;
        push(p, EV_PRESS, mode_before, 1'b1);
        if (is_long) push(p + LC, EV_LONG, 3'd0, 1'b1);
        r = p + hold;
        push(r + LAT, is_long ? EV_REL : (EV_REL | EV_SHORT), mode_after, 1'b0);
        wait_until(r);
        bus.btn = 1'b1;
        wait_until(r + 2 * LAT);
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        #20 rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        click_t     tbl[$];
        logic [2:0] prev_mode;
        int         n;
        int         p;
        int         m;

        // hold = raw cycles from PRESS to release
        for (int k = 0; k < 8; k++) tbl.push_back('{10, 1'b0, 3'(k + 1)});
        tbl.push_back('{10, 1'b0, 3'd1});
        tbl.push_back('{10, 1'b0, 3'd2});
        tbl.push_back('{10, 1'b0, 3'd3});
        tbl.push_back('{30, 1'b1, 3'd0});
        tbl.push_back('{10, 1'b0, 3'd1});
        tbl.push_back('{14, 1'b0, 3'd2});   // fall lands on hold terminal edge
        tbl.push_back('{15, 1'b1, 3'd0});   // one cycle later: long press
        for (int k = 0; k < 5; k++) tbl.push_back('{10, 1'b0, 3'(k + 1)});

        bus.btn = 1'b1;
        #1 rst_n = 1'b0;
        #100;
        check("reset outputs", 32'(all_outputs()), 32'h0);
        @(negedge clk);
        rst_n  = 1'b1;
        mon_en = 1'b1;

        // Bounce then settle pressed, then a short click
        @(negedge clk);
        n = cyc;
        for (int i = 0; i < 10; i++) begin
            wait_until(n + 2 * i);
            bus.btn = (i % 2 == 1);
        end
        wait_until(n + 20);
        bus.btn = 1'b0;
        p = n + 20 + LAT;
        push(p, EV_PRESS, 3'd0, 1'b1);
        push(p + 10 + LAT, EV_REL | EV_SHORT, 3'd1, 1'b0);
        wait_until(p - 1);
        check("bounce level one edge early", 32'(bus.btn_level), 32'h0);
        wait_until(p + 10);
        bus.btn = 1'b1;
        wait_until(p + 10 + 2 * LAT);

        pulse_reset();
        check("mode after reset", 32'(bus.mode), 32'h0);

        prev_mode = 3'd0;
        foreach (tbl[i]) begin
            run_click(tbl[i].hold, tbl[i].is_long, prev_mode, tbl[i].mode);
            prev_mode = tbl[i].mode;
        end

        // Asynchronous reset while HELD with mode 5
        @(negedge clk);
        n = cyc;
        bus.btn = 1'b0;
        push(n + LAT, EV_PRESS, 3'd5, 1'b1);
        wait_until(n + LAT + 4);
        check("held before reset", 32'(all_outputs()), 32'h85);
        #20 rst_n = 1'b0;
        #5 check("async reset clears outputs", 32'(all_outputs()), 32'h0);
        repeat (2) @(negedge clk);
        m = cyc;
        rst_n = 1'b1;
        p = m + LAT;
        push(p, EV_PRESS, 3'd0, 1'b1);
        push(p + LC, EV_LONG, 3'd0, 1'b1);
        push(p + 30 + LAT, EV_REL, 3'd0, 1'b0);

        // 3-cycle glitch while pressed
        wait_until(p + 5);
        bus.btn = 1'b1;
        wait_until(p + 8);
        bus.btn = 1'b0;
        wait_until(p + 14);
        check("glitch keeps level", 32'(bus.btn_level), 32'h1);
        wait_until(p + 30);
        bus.btn = 1'b1;

        for (int i = 0; i < 100 && sb.size() > 0; i++) @(negedge clk);
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d expected events never seen, required 0", sb.size());
        end
        repeat (4) @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
